pms_boot_sequencer: RTL and testbench

//  Hardware boot master for the PMS FPGA target: replaces the host-side boot driver.

---
 rtl/pms_boot_pkg.sv | 33 +++
 rtl/pms_boot_l2_writer.sv | 40 ++++
 rtl/pms_boot_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_pms_boot_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pms_boot_pkg.sv
// Shared types and constants for the PMS boot sequencer.
package pms_boot_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST_HOLD,
      ST_SETTLE0,
      ST_BOOTSEL,
      ST_HDR,
      ST_CHECK,
      ST_COPY,
      ST_ENTRY,
      ST_FETCH,
      ST_WAIT_EOC,
      ST_DONE,
      ST_ERROR
   } boot_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_HDR     = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_code_e;

   // Image header layout (word indices)
   localparam int unsigned HDR_BASE  = 0;
   localparam int unsigned HDR_COUNT = 1;
   localparam int unsigned HDR_ENTRY = 2;

   localparam logic [1:0]  BOOTMODE_AXI = 2'd3;
   localparam int unsigned WORD_W       = 32;

endpackage

// File: rtl/pms_boot_l2_writer.sv
// One-entry L2 write buffer with req/gnt handshake.
// The request, address and data are held until the grant cycle; a new word
// may be accepted in the grant cycle itself.
module pms_boot_l2_writer
   import pms_boot_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_addr_i,
   input  logic [WORD_W-1:0] push_data_i,
   output logic              ready_o,
   output logic              done_o,
   output logic              l2_req_o,
   input  logic              l2_gnt_i,
   output logic [ADDR_W-1:0] l2_addr_o,
   output logic [WORD_W-1:0] l2_wdata_o
);

   assign ready_o = !l2_req_o || l2_gnt_i;
   assign done_o  = l2_req_o && l2_gnt_i;

   // Load the buffer when free (or freeing this cycle), drop request on grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         l2_req_o   <= 1'b0;
         l2_addr_o  <= '0;
         l2_wdata_o <= '0;
      end else if (push_i && ready_o) begin
         l2_req_o   <= 1'b1;
         l2_addr_o  <= push_addr_i;
         l2_wdata_o <= push_data_i;
      end else if (done_o) begin
         l2_req_o   <= 1'b0;
      end
   end

endmodule

// File: rtl/pms_boot_sequencer.sv
// Hardware boot master for the PMS: reset/bootsel sequencing, image copy
// into L2, entry point programming, fetch enable and EOC wait.
// Optional EOC watchdog: define PMS_BOOT_TIMEOUT_EN.
module pms_boot_sequencer
   import pms_boot_pkg::*;
#(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned RST_CYCLES    = 64,
   parameter int unsigned SETTLE_CYCLES = 256,
   parameter int unsigned MAX_WORDS     = 65536,
   parameter logic [1:0]  BOOTMODE      = BOOTMODE_AXI
`ifdef PMS_BOOT_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC   = 2**24
`endif
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              img_req_o,
   output logic [ADDR_W-1:0] img_addr_o,
   input  logic [31:0]       img_rdata_i,
   output logic              l2_req_o,
   input  logic              l2_gnt_i,
   output logic [ADDR_W-1:0] l2_addr_o,
   output logic [31:0]       l2_wdata_o,
   output logic              pms_rst_o,
   output logic [1:0]        bootsel_o,
   output logic [31:0]       boot_addr_o,
   output logic              fetch_en_o,
   input  logic              eoc_i,
   input  logic [31:0]       exit_status_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [1:0]        err_code_o,
   output logic [31:0]       exit_status_o
);

   boot_state_e       state;
   err_code_e         err_code;
   logic [31:0]       cnt;
   logic [31:0]       rd_idx;
   logic [31:0]       wr_cnt;
   logic [31:0]       n_words;
   logic [31:0]       entry;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] push_addr;
   logic              rd_vld;
   logic              hold_vld;
   logic [31:0]       hold_data;
   logic              wr_ready;
   logic              wr_done;
   logic              wr_push;
   logic              rd_issue;

   assign busy_o     = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
   assign err_code_o = err_code;

   // The hold register buffers one read word while the writer is busy; a new
   // read is only issued once nothing is in flight and the hold slot is (or
   // is becoming) free, so returning data always has somewhere to land.
   assign wr_push  = (state == ST_COPY) && hold_vld && wr_ready;
   assign rd_issue = (state == ST_COPY) && !img_req_o && !rd_vld &&
                     (!hold_vld || wr_push) && (rd_idx != n_words);

   pms_boot_l2_writer #(
      .ADDR_W (ADDR_W)
   ) u_l2_writer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (wr_push),
      .push_addr_i (push_addr),
      .push_data_i (hold_data),
      .ready_o     (wr_ready),
      .done_o      (wr_done),
      .l2_req_o    (l2_req_o),
      .l2_gnt_i    (l2_gnt_i),
      .l2_addr_o   (l2_addr_o),
      .l2_wdata_o  (l2_wdata_o)
   );

   // Boot FSM with registered outputs, counters and header registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= ST_IDLE;
         err_code      <= ERR_NONE;
         cnt           <= '0;
         rd_idx        <= '0;
         wr_cnt        <= '0;
         n_words       <= '0;
         entry         <= '0;
         base          <= '0;
         push_addr     <= '0;
         rd_vld        <= 1'b0;
         hold_vld      <= 1'b0;
         hold_data     <= '0;
         img_req_o     <= 1'b0;
         img_addr_o    <= '0;
         pms_rst_o     <= 1'b1;
         bootsel_o     <= '0;
         boot_addr_o   <= '0;
         fetch_en_o    <= 1'b0;
         done_o        <= 1'b0;
         error_o       <= 1'b0;
         exit_status_o <= '0;
      end else begin
         rd_vld <= img_req_o;
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start_i) begin
                  state       <= ST_RST_HOLD;
                  cnt         <= '0;
                  pms_rst_o   <= 1'b1;
                  fetch_en_o  <= 1'b0;
                  boot_addr_o <= '0;
                  done_o      <= 1'b0;
                  error_o     <= 1'b0;
                  err_code    <= ERR_NONE;
               end
            end
            ST_RST_HOLD: begin
               if (cnt == RST_CYCLES - 1) begin
                  cnt       <= '0;
                  pms_rst_o <= 1'b0;
                  state     <= ST_SETTLE0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_SETTLE0: begin
               if (cnt == SETTLE_CYCLES - 1) begin
                  cnt       <= '0;
                  bootsel_o <= BOOTMODE;
                  state     <= ST_BOOTSEL;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_BOOTSEL: begin
               if (cnt == SETTLE_CYCLES - 1) begin
                  cnt        <= '0;
                  img_req_o  <= 1'b1;
                  img_addr_o <= '0;
                  state      <= ST_HDR;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_HDR: begin
               cnt <= cnt + 32'd1;
               if (cnt < HDR_ENTRY) begin
                  img_req_o  <= 1'b1;
                  img_addr_o <= img_addr_o + ADDR_W'(4);
               end else begin
                  img_req_o  <= 1'b0;
               end
               if (cnt == HDR_BASE + 1)  base    <= ADDR_W'(img_rdata_i);
               if (cnt == HDR_COUNT + 1) n_words <= img_rdata_i;
               if (cnt == HDR_ENTRY + 1) begin
                  entry <= img_rdata_i;
                  state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               push_addr <= base;
               rd_idx    <= '0;
               wr_cnt    <= '0;
               hold_vld  <= 1'b0;
               if (base[1:0] != 2'b00 || entry[1:0] != 2'b00 || n_words > MAX_WORDS) begin
                  error_o  <= 1'b1;
                  err_code <= ERR_HDR;
                  state    <= ST_ERROR;
               end else if (n_words == '0) begin
                  state <= ST_ENTRY;
               end else begin
                  state <= ST_COPY;
               end
            end
            ST_COPY: begin
               if (rd_issue) begin
                  img_req_o  <= 1'b1;
                  img_addr_o <= img_addr_o + ADDR_W'(4);
                  rd_idx     <= rd_idx + 32'd1;
               end else begin
                  img_req_o  <= 1'b0;
               end
               if (wr_push) begin
                  hold_vld  <= 1'b0;
                  push_addr <= push_addr + ADDR_W'(4);
               end
               if (rd_vld) begin
                  hold_vld  <= 1'b1;
                  hold_data <= img_rdata_i;
               end
               if (wr_done) begin
                  wr_cnt <= wr_cnt + 32'd1;
                  if (wr_cnt == n_words - 32'd1) state <= ST_ENTRY;
               end
            end
            ST_ENTRY: begin
               boot_addr_o <= entry;
               state       <= ST_FETCH;
            end
            ST_FETCH: begin
               fetch_en_o <= 1'b1;
               cnt        <= '0;
               state      <= ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
               if (eoc_i) begin
                  exit_status_o <= exit_status_i;
                  done_o        <= 1'b1;
                  state         <= ST_DONE;
               end
`ifdef PMS_BOOT_TIMEOUT_EN
               else if (cnt == TIMEOUT_CYC - 1) begin
                  error_o    <= 1'b1;
                  err_code   <= ERR_TIMEOUT;
                  fetch_en_o <= 1'b0;
                  pms_rst_o  <= 1'b1;
                  state      <= ST_ERROR;
               end else begin
                  cnt <= cnt + 32'd1;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pms_boot_sequencer.sv
// Directed self-checking bench for pms_boot_sequencer.
module tb_pms_boot_sequencer;

   localparam int unsigned RST_C = 4;
   localparam int unsigned SET_C = 8;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        img_req_o;
   logic [31:0] img_addr_o;
   logic [31:0] img_rdata_i;
   logic        l2_req_o;
   logic        l2_gnt_i;
   logic [31:0] l2_addr_o;
   logic [31:0] l2_wdata_o;
   logic        pms_rst_o;
   logic [1:0]  bootsel_o;
   logic [31:0] boot_addr_o;
   logic        fetch_en_o;
   logic        eoc_i;
   logic [31:0] exit_status_i;
   logic        busy_o;
   logic        done_o;
   logic        error_o;
   logic [1:0]  err_code_o;
   logic [31:0] exit_status_o;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk_i = ~clk_i;

   pms_boot_sequencer #(
      .ADDR_W        (32),
      .RST_CYCLES    (RST_C),
      .SETTLE_CYCLES (SET_C),
      .MAX_WORDS     (16),
      .BOOTMODE      (2'd3)
`ifdef PMS_BOOT_TIMEOUT_EN
      ,
      .TIMEOUT_CYC   (1000)
`endif
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .img_req_o     (img_req_o),
      .img_addr_o    (img_addr_o),
      .img_rdata_i   (img_rdata_i),
      .l2_req_o      (l2_req_o),
      .l2_gnt_i      (l2_gnt_i),
      .l2_addr_o     (l2_addr_o),
      .l2_wdata_o    (l2_wdata_o),
      .pms_rst_o     (pms_rst_o),
      .bootsel_o     (bootsel_o),
      .boot_addr_o   (boot_addr_o),
      .fetch_en_o    (fetch_en_o),
      .eoc_i         (eoc_i),
      .exit_status_i (exit_status_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .error_o       (error_o),
      .err_code_o    (err_code_o),
      .exit_status_o (exit_status_o)
   );

   // Image memory: data one cycle after request
   logic [31:0] img_mem [0:31];
   always @(posedge clk_i) if (img_req_o) img_rdata_i <= img_mem[img_addr_o[6:2]];

   // Grant generator: always, or one cycle in four
   int          gmode = 0;
   int unsigned gcnt  = 0;
   always @(negedge clk_i) begin
      gcnt++;
      l2_gnt_i = (gmode == 0) || (gcnt % 4 == 0);
   end

   // L2 monitor: completed writes and hold-while-stalled violations
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          stall_viol = 0;
   int          req_cyc    = 0;
   logic        prev_stall = 1'b0;
   logic        prev_rst   = 1'b1;
   logic [31:0] prev_a     = '0;
   logic [31:0] prev_d     = '0;
   always @(posedge clk_i) begin
      if (prev_stall && !prev_rst &&
          (l2_req_o !== 1'b1 || l2_addr_o !== prev_a || l2_wdata_o !== prev_d))
         stall_viol++;
      if (l2_req_o === 1'b1 && l2_gnt_i === 1'b1) begin
         wa_q.push_back(l2_addr_o);
         wd_q.push_back(l2_wdata_o);
      end
      if (l2_req_o === 1'b1) req_cyc++;
      prev_stall = (l2_req_o === 1'b1) && (l2_gnt_i !== 1'b1);
      prev_a     = l2_addr_o;
      prev_d     = l2_wdata_o;
      prev_rst   = rst_i;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
   endtask

   task automatic load_image(input logic [31:0] base, input logic [31:0] n,
                             input logic [31:0] entry, input int seed);
      img_mem[0] = base;
      img_mem[1] = n;
      img_mem[2] = entry;
      for (int i = 3; i < 32; i++) img_mem[i] = 32'(seed) * 32'h0101_0000 + 32'(i * 7);
   endtask

   // Wait for fetch enable or error, bounded
   task automatic wait_end(input int limit, output int n);
      n = 0;
      while (fetch_en_o !== 1'b1 && error_o !== 1'b1 && n < limit) begin
         @(posedge clk_i);
         #1;
         n++;
      end
   endtask

   task automatic chk_writes(input string tag, input int first, input int n, input logic [31:0] base);
      chk({tag, "_wr_count"}, 32'(wa_q.size() - first), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (first + i < wa_q.size()) begin
            chk({tag, "_wr_addr"}, wa_q[first + i], base + 32'(4 * i));
            chk({tag, "_wr_data"}, wd_q[first + i], img_mem[3 + i]);
         end
      end
   endtask

   task automatic run_bad(input string tag, input logic [31:0] base, input logic [31:0] n,
                          input logic [31:0] entry);
      int first;
      int w;
      load_image(base, n, entry, 9);
      first = wa_q.size();
      pulse_start();
      wait_end(1000, w);
      chk({tag, "_wait"}, 32'(w < 1000), 32'd1);
      chk({tag, "_error"}, 32'(error_o), 32'd1);
      chk({tag, "_err_code"}, 32'(err_code_o), 32'd1);
      chk({tag, "_fetch"}, 32'(fetch_en_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_no_l2"}, 32'(wa_q.size() - first), 32'd0);
   endtask

   initial begin
      int n;
      int first;
      int rq0;

      rst_i = 1'b1;
      start_i = 1'b0;
      eoc_i = 1'b0;
      exit_status_i = '0;
      tick(3);
      chk("rst_pms_rst", 32'(pms_rst_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_error", 32'(error_o), 32'd0);
      chk("rst_err_code", 32'(err_code_o), 32'd0);
      chk("rst_bootsel", 32'(bootsel_o), 32'd0);
      chk("rst_fetch", 32'(fetch_en_o), 32'd0);
      chk("rst_l2_req", 32'(l2_req_o), 32'd0);
      chk("rst_img_req", 32'(img_req_o), 32'd0);
      chk("rst_boot_addr", boot_addr_o, 32'd0);
      chk("rst_exit", exit_status_o, 32'd0);
      rst_i = 1'b0;
      tick(2);
      chk("idle_busy", 32'(busy_o), 32'd0);

      // Nominal boot
      gmode = 0;
      load_image(32'h1C00_8000, 32'd4, 32'h1C00_8080, 1);
      first = wa_q.size();
      pulse_start();
      chk("nom_busy", 32'(busy_o), 32'd1);
      chk("nom_rst_hold", 32'(pms_rst_o), 32'd1);
      n = 0;
      while (pms_rst_o === 1'b1 && n < 100) begin tick(1); n++; end
      chk("nom_rst_cycles", 32'(n), RST_C);
      chk("nom_bootsel_pre", 32'(bootsel_o), 32'd0);
      n = 0;
      while (bootsel_o !== 2'd3 && n < 100) begin tick(1); n++; end
      chk("nom_settle_cycles", 32'(n), SET_C);
      wait_end(1000, n);
      chk("nom_wait", 32'(n < 1000), 32'd1);
      chk_writes("nom", first, 4, 32'h1C00_8000);
      chk("nom_boot_addr", boot_addr_o, 32'h1C00_8080);
      chk("nom_fetch", 32'(fetch_en_o), 32'd1);
      chk("nom_pms_rst", 32'(pms_rst_o), 32'd0);
      tick(5);
      chk("nom_waiting_eoc", 32'(done_o), 32'd0);
      exit_status_i = 32'h600D_0001;
      eoc_i = 1'b1;
      tick(1);
      chk("nom_done", 32'(done_o), 32'd1);
      chk("nom_exit", exit_status_o, 32'h600D_0001);
      chk("nom_busy_done", 32'(busy_o), 32'd0);
      chk("nom_fetch_held", 32'(fetch_en_o), 32'd1);
      eoc_i = 1'b0;
      exit_status_i = '0;

      // Backpressure, N at the MAX_WORDS boundary, start while busy ignored
      gmode = 1;
      load_image(32'h1C01_0000, 32'd16, 32'h1C01_0100, 2);
      first = wa_q.size();
      rq0 = req_cyc;
      pulse_start();
      chk("bp_done_cleared", 32'(done_o), 32'd0);
      tick(40);
      pulse_start();
      chk("bp_busy", 32'(busy_o), 32'd1);
      wait_end(3000, n);
      chk("bp_wait", 32'(n < 3000), 32'd1);
      chk_writes("bp", first, 16, 32'h1C01_0000);
      chk("bp_stalled", 32'(req_cyc - rq0 > 16), 32'd1);
      chk("bp_stable", 32'(stall_viol), 32'd0);
      chk("bp_boot_addr", boot_addr_o, 32'h1C01_0100);
      exit_status_i = 32'h1234_5678;
      eoc_i = 1'b1;
      tick(1);
      chk("bp_done", 32'(done_o), 32'd1);
      chk("bp_exit", exit_status_o, 32'h1234_5678);
      eoc_i = 1'b0;
      gmode = 0;

      // Header errors
      run_bad("bad_base", 32'h1C00_8002, 32'd4, 32'h1C00_8080);
      run_bad("bad_entry", 32'h1C00_8000, 32'd4, 32'h1C00_8081);
      run_bad("bad_count", 32'h1C00_8000, 32'd17, 32'h1C00_8080);

      // N == 0, restart from ERROR
      load_image(32'h1C00_8000, 32'd0, 32'h1C00_80F0, 4);
      first = wa_q.size();
      pulse_start();
      chk("n0_error_cleared", 32'(error_o), 32'd0);
      chk("n0_err_code_cleared", 32'(err_code_o), 32'd0);
      wait_end(1000, n);
      chk("n0_wait", 32'(n < 1000), 32'd1);
      chk("n0_no_l2", 32'(wa_q.size() - first), 32'd0);
      chk("n0_fetch", 32'(fetch_en_o), 32'd1);
      chk("n0_boot_addr", boot_addr_o, 32'h1C00_80F0);
      exit_status_i = 32'h0;
      eoc_i = 1'b1;
      tick(1);
      chk("n0_done", 32'(done_o), 32'd1);
      chk("n0_exit", exit_status_o, 32'h0);
      eoc_i = 1'b0;

      // Reset mid-copy, then a clean restart
      load_image(32'h1C02_0000, 32'd16, 32'h1C02_0040, 3);
      first = wa_q.size();
      pulse_start();
      n = 0;
      while (wa_q.size() - first < 5 && n < 1000) begin tick(1); n++; end
      chk("mid_reach_word5", 32'(n < 1000), 32'd1);
      rst_i = 1'b1;
      tick(1);
      chk("mid_pms_rst", 32'(pms_rst_o), 32'd1);
      chk("mid_l2_req", 32'(l2_req_o), 32'd0);
      chk("mid_fetch", 32'(fetch_en_o), 32'd0);
      chk("mid_busy", 32'(busy_o), 32'd0);
      chk("mid_img_req", 32'(img_req_o), 32'd0);
      chk("mid_bootsel", 32'(bootsel_o), 32'd0);
      rst_i = 1'b0;
      tick(1);
      first = wa_q.size();
      pulse_start();
      wait_end(1000, n);
      chk("mid_re_wait", 32'(n < 1000), 32'd1);
      chk_writes("mid_re", first, 16, 32'h1C02_0000);
      chk("mid_re_fetch", 32'(fetch_en_o), 32'd1);
      chk("mid_re_boot_addr", boot_addr_o, 32'h1C02_0040);

`ifdef PMS_BOOT_TIMEOUT_EN
      // EOC watchdog
      n = 0;
      while (error_o !== 1'b1 && n < 1100) begin tick(1); n++; end
      chk("to_cycles", 32'(n), 32'd1000);
      chk("to_err_code", 32'(err_code_o), 32'd2);
      chk("to_fetch", 32'(fetch_en_o), 32'd0);
      chk("to_pms_rst", 32'(pms_rst_o), 32'd1);
      chk("to_done", 32'(done_o), 32'd0);
`else
      // No watchdog: WAIT_EOC persists
      tick(300);
      chk("noto_error", 32'(error_o), 32'd0);
      chk("noto_busy", 32'(busy_o), 32'd1);
      chk("noto_fetch", 32'(fetch_en_o), 32'd1);
      exit_status_i = 32'hCAFE_0002;
      eoc_i = 1'b1;
      tick(1);
      chk("noto_done", 32'(done_o), 32'd1);
      chk("noto_exit", exit_status_o, 32'hCAFE_0002);
      eoc_i = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
